// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core, the external loader/debug port and a single-port memory.
// The arbiter takes the master modport; the surrounding environment takes the slave modport.
interface mem_arbiter_if;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_wr_data;
    logic        core_wr_ena;
    logic [31:0] core_rd_data;
    logic        core_ena;

    logic        ext_req;
    logic [31:0] ext_addr;
    logic [31:0] ext_wr_data;
    logic        ext_wr_ena;
    logic        ext_gnt;
    logic        ext_rd_valid;
    logic [31:0] ext_rd_data;

    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    modport master (
        input  core_req, core_addr, core_wr_data, core_wr_ena,
        input  ext_req, ext_addr, ext_wr_data, ext_wr_ena,
        input  mem_rd_data,
        output core_rd_data, core_ena,
        output ext_gnt, ext_rd_valid, ext_rd_data,
        output mem_addr, mem_wr_data, mem_wr_ena
    );

    modport slave (
        output core_req, core_addr, core_wr_data, core_wr_ena,
        output ext_req, ext_addr, ext_wr_data, ext_wr_ena,
        output mem_rd_data,
        input  core_rd_data, core_ena,
        input  ext_gnt, ext_rd_valid, ext_rd_data,
        input  mem_addr, mem_wr_data, mem_wr_ena
    );
endinterface

// File: rtl/mem_arbiter.sv
// Core/external arbiter for one single-port memory. The core has priority, but an
// external request never waits more than WAIT_LIMIT cycles before it is served.
module mem_arbiter #(
    parameter int WAIT_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CORE_RD = 2'd1,
        S_EXT_RD  = 2'd2,
        S_WRITE   = 2'd3
    } state_e;

    // Keep the counter at least one bit wide so WAIT_LIMIT=0 still elaborates.
    localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           ext_gnt;
    logic           core_gnt;

    always_comb begin
        ext_gnt    = rst & bus.ext_req & (~bus.core_req | (wait_cnt_q == WAIT_MAX));
        core_gnt   = rst & bus.core_req & ~ext_gnt;

        wait_cnt_d = '0;
        if (bus.ext_req && !ext_gnt)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

        state_d = S_IDLE;
        if (ext_gnt)
            state_d = bus.ext_wr_ena ? S_WRITE : S_EXT_RD;
        else if (core_gnt)
            state_d = bus.core_wr_ena ? S_WRITE : S_CORE_RD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Idle port parks on the core address so the core's next read is already presented.
    assign bus.mem_addr     = ext_gnt ? bus.ext_addr    : bus.core_addr;
    assign bus.mem_wr_data  = ext_gnt ? bus.ext_wr_data : bus.core_wr_data;
    assign bus.mem_wr_ena   = (ext_gnt & bus.ext_wr_ena) | (core_gnt & bus.core_wr_ena);

    assign bus.core_ena     = rst & ~(bus.core_req & ~core_gnt);
    assign bus.core_rd_data = bus.mem_rd_data;

    // Read data lands one cycle after the grant, so the registered owner steers it.
    assign bus.ext_gnt      = ext_gnt;
    assign bus.ext_rd_valid = rst & (state_q == S_EXT_RD);
    assign bus.ext_rd_data  = bus.ext_rd_valid ? bus.mem_rd_data : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model; a second
// instance with WAIT_LIMIT=0 shadows the same inputs to check ext always wins.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem [0:63];
    logic [31:0] rdexp [3];

    mem_arbiter_if bus ();
    mem_arbiter_if if0 ();

    mem_arbiter #(.WAIT_LIMIT(3)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.WAIT_LIMIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    assign if0.core_req     = bus.core_req;
    assign if0.core_addr    = bus.core_addr;
    assign if0.core_wr_data = bus.core_wr_data;
    assign if0.core_wr_ena  = bus.core_wr_ena;
    assign if0.ext_req      = bus.ext_req;
    assign if0.ext_addr     = bus.ext_addr;
    assign if0.ext_wr_data  = bus.ext_wr_data;
    assign if0.ext_wr_ena   = bus.ext_wr_ena;
    assign if0.mem_rd_data  = bus.mem_rd_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr_ena) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
        bus.mem_rd_data <= mem[bus.mem_addr[7:2]];
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[4] = 32'hDEAD_BEEF;
        rdexp[0] = 32'h1111_1111;
        rdexp[1] = 32'h2222_2222;
        rdexp[2] = 32'h3333_3333;

        // Reset with both requesters active: everything must stay quiet.
        rst = 1'b0;
        bus.core_req = 1'b1; bus.core_addr = 32'h0; bus.core_wr_data = 32'h0; bus.core_wr_ena = 1'b1;
        bus.ext_req  = 1'b1; bus.ext_addr  = 32'h0; bus.ext_wr_data  = 32'h0; bus.ext_wr_ena  = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        chk1("rst_core_ena", bus.core_ena, 1'b0);
        chk1("rst_ext_gnt", bus.ext_gnt, 1'b0);
        chk1("rst_mem_wr_ena", bus.mem_wr_ena, 1'b0);
        chk1("rst_ext_rd_valid", bus.ext_rd_valid, 1'b0);
        chk32("rst_ext_rd_data", bus.ext_rd_data, 32'h0);
        chk32("rst_state", 32'(dut.state_q), 32'd0);
        chk32("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

        step();
        rst = 1'b1;
        bus.core_req = 1'b0; bus.core_wr_ena = 1'b0;
        bus.ext_req  = 1'b0; bus.ext_wr_ena  = 1'b0;

        // Core read of 0x10.
        step();
        bus.core_req = 1'b1; bus.core_addr = 32'h10;
        #4;
        chk32("core_rd_mem_addr", bus.mem_addr, 32'h10);
        chk1("core_rd_core_ena", bus.core_ena, 1'b1);
        chk1("core_rd_ext_gnt", bus.ext_gnt, 1'b0);
        step();
        bus.core_req = 1'b0; bus.core_addr = 32'h14;
        #4;
        chk32("core_rd_data", bus.core_rd_data, 32'hDEAD_BEEF);
        chk32("idle_mem_addr", bus.mem_addr, 32'h14);
        chk1("idle_mem_wr_ena", bus.mem_wr_ena, 1'b0);
        chk1("core_rd_no_ext_valid", bus.ext_rd_valid, 1'b0);
        chk32("core_rd_ext_data_zero", bus.ext_rd_data, 32'h0);

        // Continuous contention: ext wins one cycle in four; the WAIT_LIMIT=0 copy always picks ext.
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                bus.core_req = 1'b1; bus.core_addr = 32'h0;
                bus.ext_req  = 1'b1; bus.ext_addr  = 32'h8;
            end
            #4;
            chk1("cont_ext_gnt", bus.ext_gnt, (i % 4) == 3);
            chk1("cont_core_ena", bus.core_ena, (i % 4) != 3);
            chk32("cont_mem_addr", bus.mem_addr, ((i % 4) == 3) ? 32'h8 : 32'h0);
            chk32("cont_wait_cnt", 32'(dut.wait_cnt_q), 32'(i % 4));
            chk1("cont_ext_rd_valid", bus.ext_rd_valid, i == 4);
            if (i == 4) chk32("cont_ext_rd_data", bus.ext_rd_data, 32'h3333_3333);
            chk1("wl0_ext_gnt", if0.ext_gnt, 1'b1);
            chk1("wl0_core_ena", if0.core_ena, 1'b0);
        end

        // Ext write 0xAA to 0x20, then read it back.
        step();
        bus.core_req = 1'b0;
        bus.ext_req = 1'b1; bus.ext_wr_ena = 1'b1; bus.ext_addr = 32'h20; bus.ext_wr_data = 32'hAA;
        #4;
        chk1("ext_wr_gnt", bus.ext_gnt, 1'b1);
        chk1("ext_wr_mem_wr_ena", bus.mem_wr_ena, 1'b1);
        chk32("ext_wr_mem_wr_data", bus.mem_wr_data, 32'hAA);
        chk32("ext_wr_mem_addr", bus.mem_addr, 32'h20);
        step();
        bus.ext_wr_ena = 1'b0;
        #4;
        chk1("ext_rd_gnt", bus.ext_gnt, 1'b1);
        chk1("ext_rd_mem_wr_ena", bus.mem_wr_ena, 1'b0);
        chk1("ext_rd_after_wr_valid", bus.ext_rd_valid, 1'b0);
        step();
        bus.ext_req = 1'b0;
        #4;
        chk1("ext_rd_valid", bus.ext_rd_valid, 1'b1);
        chk32("ext_rd_data", bus.ext_rd_data, 32'hAA);

        // Back-to-back ext reads of 0x0, 0x4, 0x8.
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 3) begin
                bus.ext_req = 1'b1; bus.ext_addr = 32'(4 * k);
            end else begin
                bus.ext_req = 1'b0;
            end
            #4;
            chk1("b2b_valid", bus.ext_rd_valid, (k >= 1) && (k <= 3));
            if (k >= 1 && k <= 3) chk32("b2b_data", bus.ext_rd_data, rdexp[k-1]);
        end

        // Core write of 0x12345678 to 0x40.
        step();
        bus.core_req = 1'b1; bus.core_wr_ena = 1'b1; bus.core_addr = 32'h40; bus.core_wr_data = 32'h1234_5678;
        #4;
        chk1("core_wr_mem_wr_ena", bus.mem_wr_ena, 1'b1);
        chk32("core_wr_mem_wr_data", bus.mem_wr_data, 32'h1234_5678);
        chk32("core_wr_mem_addr", bus.mem_addr, 32'h40);
        chk1("core_wr_core_ena", bus.core_ena, 1'b1);
        chk1("core_wr_ext_rd_valid", bus.ext_rd_valid, 1'b0);
        step();
        bus.core_req = 1'b0; bus.core_wr_ena = 1'b0;
        #4;
        chk32("core_wr_state", 32'(dut.state_q), 32'd3);
        chk1("core_wr_no_ext_valid", bus.ext_rd_valid, 1'b0);

        // Reset lands while an ext read's data is due.
        step();
        bus.ext_req = 1'b1; bus.ext_addr = 32'h4;
        #4;
        chk1("abort_ext_gnt", bus.ext_gnt, 1'b1);
        step();
        bus.core_req = 1'b1;
        #1;
        chk1("abort_pre_valid", bus.ext_rd_valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk1("abort_ext_rd_valid", bus.ext_rd_valid, 1'b0);
        chk1("abort_ext_gnt_low", bus.ext_gnt, 1'b0);
        chk1("abort_mem_wr_ena", bus.mem_wr_ena, 1'b0);
        chk1("abort_core_ena", bus.core_ena, 1'b0);
        chk32("abort_ext_rd_data", bus.ext_rd_data, 32'h0);
        step();
        chk32("abort_state", 32'(dut.state_q), 32'd0);
        chk32("abort_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        rst = 1'b1;
        #1;
        chk32("release_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        chk1("release_core_ena", bus.core_ena, 1'b1);
        chk1("release_ext_gnt", bus.ext_gnt, 1'b0);
        step();
        chk32("release_wait_inc", 32'(dut.wait_cnt_q), 32'd1);
        bus.core_req = 1'b0; bus.ext_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
